// File: rtl/chipset_bus_sizer.sv
// chipset_bus_sizer: turns one CPU access to the chip-register space into
// one or two 16-bit register-engine cycles. It also raises the CPU
// transfer acknowledge or transfer error.
// A long access is split into a high word (CA1=0) and then a low word (CA1=1).
// Illegal sizes and misaligned accesses are answered with a one-cycle nTEA.
// In that case the register engine is not started.
module chipset_bus_sizer (
   input  logic       CLK40,
   input  logic       nRESET,
   input  logic       nTS,
   input  logic       nREGSEL,
   input  logic       RnW,
   input  logic [1:0] SIZ,
   input  logic [1:0] A,
   input  logic       REG_TA,
   output logic       nREGSPACE,
   output logic       CA1,
   output logic       UDS_SEL,
   output logic       LDS_SEL,
   output logic       WR_HI,
   output logic       LATCH_HI,
   output logic       LATCH_LO,
   output logic       nTA,
   output logic       nTEA,
   output logic       BUSY
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WORD0 = 3'd1,
      WORD1 = 3'd2,
      ACK   = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam logic [1:0] SIZ_LONG = 2'b00;
   localparam logic [1:0] SIZ_BYTE = 2'b01;
   localparam logic [1:0] SIZ_WORD = 2'b10;
   localparam logic [1:0] SIZ_LINE = 2'b11;

   state_t state_q, state_d;
   logic   rnw_q, rnw_d;
   logic   long_q, long_d;
   logic   reg_ta_q;
   logic   nregspace_q, nregspace_d;
   logic   ca1_q, ca1_d;
   logic   uds_q, uds_d;
   logic   lds_q, lds_d;
   logic   wr_hi_q, wr_hi_d;
   logic   latch_hi_q, latch_hi_d;
   logic   latch_lo_q, latch_lo_d;
   logic   nta_q, nta_d;
   logic   ntea_q, ntea_d;
   logic   busy_q, busy_d;

   logic   ta_edge;
   logic   start;
   logic   bad_access;

   // REG_TA counts only on a 0->1 transition.
   // A held-high done line therefore finishes exactly one word.
   assign ta_edge = REG_TA & ~reg_ta_q;
   assign start   = ~nTS & ~nREGSEL;
   assign bad_access = (SIZ == SIZ_LINE) ||
                       ((SIZ == SIZ_WORD) && A[0]) ||
                       ((SIZ == SIZ_LONG) && (A != 2'b00));

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      rnw_d       = rnw_q;
      long_d      = long_q;
      nregspace_d = nregspace_q;
      ca1_d       = ca1_q;
      uds_d       = uds_q;
      lds_d       = lds_q;
      latch_hi_d  = 1'b0;
      latch_lo_d  = 1'b0;
      nta_d       = 1'b1;
      ntea_d      = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               rnw_d  = RnW;
               long_d = (SIZ == SIZ_LONG);
               if (bad_access) begin
                  state_d = ERR;
                  ntea_d  = 1'b0;
               end else begin
                  state_d     = WORD0;
                  nregspace_d = 1'b0;
                  // A long access always starts with the high word.
                  ca1_d       = (SIZ == SIZ_LONG) ? 1'b0 : A[1];
                  uds_d       = (SIZ == SIZ_BYTE) ? ~A[0] : 1'b1;
                  lds_d       = (SIZ == SIZ_BYTE) ?  A[0] : 1'b1;
               end
            end
         end
         WORD0: begin
            if (ta_edge) begin
               latch_hi_d = rnw_q & ~ca1_q;
               latch_lo_d = rnw_q &  ca1_q;
               if (long_q) begin
                  // nREGSPACE stays low so that the engine sees one continuous request.
                  state_d = WORD1;
                  ca1_d   = 1'b1;
               end else begin
                  state_d     = ACK;
                  nregspace_d = 1'b1;
                  nta_d       = 1'b0;
               end
            end
         end
         WORD1: begin
            if (ta_edge) begin
               latch_hi_d  = rnw_q & ~ca1_q;
               latch_lo_d  = rnw_q &  ca1_q;
               state_d     = ACK;
               nregspace_d = 1'b1;
               nta_d       = 1'b0;
            end
         end
         ACK:     state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      wr_hi_d = ~ca1_d;
      busy_d  = (state_d != IDLE);
   end

   // State, captured request and output registers; async active-low reset
   always_ff @(posedge CLK40 or negedge nRESET) begin
      if (!nRESET) begin
         state_q     <= IDLE;
         rnw_q       <= 1'b0;
         long_q      <= 1'b0;
         reg_ta_q    <= 1'b0;
         nregspace_q <= 1'b1;
         ca1_q       <= 1'b0;
         uds_q       <= 1'b0;
         lds_q       <= 1'b0;
         wr_hi_q     <= 1'b1;
         latch_hi_q  <= 1'b0;
         latch_lo_q  <= 1'b0;
         nta_q       <= 1'b1;
         ntea_q      <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rnw_q       <= rnw_d;
         long_q      <= long_d;
         reg_ta_q    <= REG_TA;
         nregspace_q <= nregspace_d;
         ca1_q       <= ca1_d;
         uds_q       <= uds_d;
         lds_q       <= lds_d;
         wr_hi_q     <= wr_hi_d;
         latch_hi_q  <= latch_hi_d;
         latch_lo_q  <= latch_lo_d;
         nta_q       <= nta_d;
         ntea_q      <= ntea_d;
         busy_q      <= busy_d;
      end
   end

   assign nREGSPACE = nregspace_q;
   assign CA1       = ca1_q;
   assign UDS_SEL   = uds_q;
   assign LDS_SEL   = lds_q;
   assign WR_HI     = wr_hi_q;
   assign LATCH_HI  = latch_hi_q;
   assign LATCH_LO  = latch_lo_q;
   assign nTA       = nta_q;
   assign nTEA      = ntea_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_chipset_bus_sizer.sv
// Bench for chipset_bus_sizer. It applies directed cycle tables and a reset-in-WORD1 sequence.
// It then applies random traffic that is checked against a transaction-level model.
// The model keeps a queue of the words still owed to the CPU.
`timescale 1ns/100ps
module tb_chipset_bus_sizer;

   logic       CLK40 = 1'b0;
   logic       nRESET = 1'b0;
   logic       nTS = 1'b1, nREGSEL = 1'b1, RnW = 1'b0, REG_TA = 1'b0;
   logic [1:0] SIZ = 2'b00, A = 2'b00;
   logic       nREGSPACE, CA1, UDS_SEL, LDS_SEL, WR_HI, LATCH_HI, LATCH_LO, nTA, nTEA, BUSY;

   int vectors = 0;
   int miscompares = 0;

   always #12.5 CLK40 = ~CLK40;

   chipset_bus_sizer dut (
      .CLK40(CLK40), .nRESET(nRESET), .nTS(nTS), .nREGSEL(nREGSEL), .RnW(RnW),
      .SIZ(SIZ), .A(A), .REG_TA(REG_TA), .nREGSPACE(nREGSPACE), .CA1(CA1),
      .UDS_SEL(UDS_SEL), .LDS_SEL(LDS_SEL), .WR_HI(WR_HI), .LATCH_HI(LATCH_HI),
      .LATCH_LO(LATCH_LO), .nTA(nTA), .nTEA(nTEA), .BUSY(BUSY)
   );

   // Output order is {nREGSPACE,CA1,UDS,LDS,WR_HI,LATCH_HI,LATCH_LO,nTA,nTEA,BUSY}.
   localparam logic [9:0] RST_VEC = 10'b1000100110;

   function automatic logic [9:0] outs();
      return {nREGSPACE, CA1, UDS_SEL, LDS_SEL, WR_HI, LATCH_HI, LATCH_LO, nTA, nTEA, BUSY};
   endfunction

   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] act;
      act = outs();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %b want %b (nREGSPACE,CA1,UDS,LDS,WR_HI,LHI,LLO,nTA,nTEA,BUSY)",
                  name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic nts, input logic nsel, input logic rnw,
                        input logic [1:0] siz, input logic [1:0] a, input logic ta);
      nTS = nts; nREGSEL = nsel; RnW = rnw; SIZ = siz; A = a; REG_TA = ta;
   endtask

   task automatic tick();
      @(posedge CLK40);
      #1;
   endtask

   // ---------------- reference model ----------------
   int   q_words[$];        // CA1 of each word still to be transferred
   logic m_ca1, m_uds, m_lds, m_rnw, m_prev, m_nta, m_ntea, m_lhi, m_llo;

   task automatic m_reset();
      q_words.delete();
      m_ca1 = 0; m_uds = 0; m_lds = 0; m_rnw = 0; m_prev = 0;
      m_nta = 1; m_ntea = 1; m_lhi = 0; m_llo = 0;
   endtask

   task automatic m_step(input logic nts, input logic nsel, input logic rnw,
                         input logic [1:0] siz, input logic [1:0] a, input logic ta);
      bit edge_seen, idle, bad;
      edge_seen = ta && !m_prev;
      m_prev = ta;
      idle = (q_words.size() == 0) && m_nta && m_ntea;
      m_lhi = 0; m_llo = 0; m_nta = 1; m_ntea = 1;
      if (idle) begin
         if (!nts && !nsel) begin
            bad = (siz == 2'b11) || (siz == 2'b10 && a[0]) || (siz == 2'b00 && a != 2'b00);
            if (bad) m_ntea = 0;
            else begin
               m_rnw = rnw;
               if (siz == 2'b00) q_words = '{0, 1};
               else q_words = '{int'(a[1])};
               m_ca1 = logic'(q_words[0]);
               m_uds = (siz == 2'b01) ? !a[0] : 1'b1;
               m_lds = (siz == 2'b01) ?  a[0] : 1'b1;
            end
         end
      end else if (q_words.size() > 0 && edge_seen) begin
         if (m_rnw) begin
            if (m_ca1) m_llo = 1; else m_lhi = 1;
         end
         void'(q_words.pop_front());
         if (q_words.size() > 0) m_ca1 = logic'(q_words[0]);
         else m_nta = 0;
      end
   endtask

   function automatic logic [9:0] m_exp();
      logic pending;
      pending = (q_words.size() > 0);
      return {!pending, m_ca1, m_uds, m_lds, !m_ca1, m_lhi, m_llo, m_nta, m_ntea,
              pending || !m_nta || !m_ntea};
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic       nts, nsel, rnw;
      logic [1:0] siz, a;
      logic       ta;
      logic [9:0] exp;
   } vec_t;

   vec_t tbl[28];

   initial begin
      // byte write SIZ=01 A=01
      tbl[0]  = '{0,0,0,2'b01,2'b01,0,10'b0001100111};
      tbl[1]  = '{1,0,0,2'b01,2'b01,0,10'b0001100111};
      tbl[2]  = '{1,0,0,2'b01,2'b01,1,10'b1001100011};
      tbl[3]  = '{1,0,0,2'b01,2'b01,0,10'b1001100110};
      // long read: high word, then low word, one nTA
      tbl[4]  = '{0,0,1,2'b00,2'b00,0,10'b0011100111};
      tbl[5]  = '{1,0,1,2'b00,2'b00,1,10'b0111010111};
      tbl[6]  = '{1,0,1,2'b00,2'b00,1,10'b0111000111};
      tbl[7]  = '{1,0,1,2'b00,2'b00,0,10'b0111000111};
      tbl[8]  = '{1,0,1,2'b00,2'b00,1,10'b1111001011};
      tbl[9]  = '{1,0,1,2'b00,2'b00,0,10'b1111000110};
      // line and misaligned long produce errors
      tbl[10] = '{0,0,1,2'b11,2'b00,0,10'b1111000101};
      tbl[11] = '{1,0,1,2'b11,2'b00,0,10'b1111000110};
      tbl[12] = '{0,0,1,2'b00,2'b10,0,10'b1111000101};
      tbl[13] = '{1,0,1,2'b00,2'b10,0,10'b1111000110};
      // not selected, and REG_TA while idle
      tbl[14] = '{0,1,1,2'b01,2'b00,0,10'b1111000110};
      tbl[15] = '{1,1,1,2'b01,2'b00,1,10'b1111000110};
      tbl[16] = '{1,1,1,2'b01,2'b00,0,10'b1111000110};
      // byte read with REG_TA held high for 3 cycles
      tbl[17] = '{0,0,1,2'b01,2'b10,0,10'b0110000111};
      tbl[18] = '{1,0,1,2'b01,2'b10,1,10'b1110001011};
      tbl[19] = '{1,0,1,2'b01,2'b10,1,10'b1110000110};
      tbl[20] = '{1,0,1,2'b01,2'b10,1,10'b1110000110};
      tbl[21] = '{1,0,1,2'b01,2'b10,0,10'b1110000110};
      // word write; nTS during ACK ignored, nTS in following IDLE accepted
      tbl[22] = '{0,0,0,2'b10,2'b00,0,10'b0011100111};
      tbl[23] = '{1,0,0,2'b10,2'b00,1,10'b1011100011};
      tbl[24] = '{0,0,0,2'b01,2'b11,0,10'b1011100110};
      tbl[25] = '{0,0,0,2'b01,2'b11,0,10'b0101000111};
      tbl[26] = '{1,0,0,2'b01,2'b11,1,10'b1101000011};
      tbl[27] = '{1,0,0,2'b01,2'b11,0,10'b1101000110};
   end

   initial begin
      logic rst_now;
      #30;
      check("reset_state", RST_VEC);
      #3 nRESET = 1'b1;
      tick();
      check("idle_after_release", RST_VEC);

      for (int i = 0; i < 28; i++) begin
         drive(tbl[i].nts, tbl[i].nsel, tbl[i].rnw, tbl[i].siz, tbl[i].a, tbl[i].ta);
         tick();
         check($sformatf("tbl[%0d]", i), tbl[i].exp);
      end

      // reset pulsed while in WORD1 of a long read
      drive(0,0,1,2'b00,2'b00,0); tick(); check("lr_word0", 10'b0011100111);
      drive(1,0,1,2'b00,2'b00,1); tick(); check("lr_word1", 10'b0111010111);
      drive(1,0,1,2'b00,2'b00,0);
      #5 nRESET = 1'b0;
      #1 check("rst_async", RST_VEC);
      tick(); check("rst_held", RST_VEC);
      nRESET = 1'b1;
      drive(1,0,1,2'b00,2'b00,1); tick(); check("rst_no_ta", RST_VEC);
      drive(0,0,1,2'b10,2'b10,0); tick(); check("post_rst_word0", 10'b0111000111);
      drive(1,0,1,2'b10,2'b10,1); tick(); check("post_rst_ack", 10'b1111001011);
      drive(1,0,1,2'b10,2'b10,0); tick(); check("post_rst_idle", 10'b1111000110);

      // randomized traffic against the model
      nRESET = 1'b0;
      m_reset();
      tick();
      nRESET = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst_now = ($urandom_range(0, 249) == 0);
         if (rst_now) begin
            nRESET = 1'b0;
            m_reset();
            #2 check($sformatf("rnd_rst[%0d]", c), m_exp());
            tick();
            nRESET = 1'b1;
         end else begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
            m_step(nTS, nREGSEL, RnW, SIZ, A, REG_TA);
            tick();
            check($sformatf("rnd[%0d]", c), m_exp());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/chipset_bus_sizer.md
CHIPSET_BUS_SIZER -- requirements
Module: chipset_bus_sizer

Interface
REQ-001 SHALL: CLK40  in  1  40 MHz system clock; all state changes on rising edge.
REQ-002 SHALL: nRESET  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: nTS  in  1  CPU transfer start, active-low, one CLK40 cycle.
REQ-004 SHALL: nREGSEL  in  1  decoded chip-register address space, active-low, valid with nTS.
REQ-005 SHALL: RnW  in  1  CPU direction, 1=read.
REQ-006 SHALL: SIZ  in  2  CPU size: 00 long, 01 byte, 10 word, 11 line.
REQ-007 SHALL: A  in  2  CPU address bits [1:0].
REQ-008 SHALL: REG_TA  in  1  per-word done pulse from the register cycle engine.
REQ-009 SHALL: nREGSPACE  out  1  active-low request to the register cycle engine.
REQ-010 SHALL: CA1  out  1  chipset word address bit A1.
REQ-011 SHALL: UDS_SEL, LDS_SEL  out  1 each  byte-lane enables for the current word.
REQ-012 SHALL: WR_HI  out  1  write mux select: 1=CPU D31:16, 0=CPU D15:0 onto chip bus.
REQ-013 SHALL: LATCH_HI, LATCH_LO  out  1 each  one-cycle read-capture strobes for CPU D31:16 / D15:0.
REQ-014 SHALL: nTA, nTEA  out  1 each  CPU transfer acknowledge / transfer error, active-low.
REQ-015 SHALL: BUSY  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL: state machine states IDLE, WORD0, WORD1, ACK, ERR; all outputs registered.
REQ-017 SHALL: in IDLE, on nTS=0 and nREGSEL=0, capture RnW, SIZ, A; nTS with nREGSEL=1 produces no response.
REQ-018 SHALL: go to ERR if SIZ=11, SIZ=10 with A[0]=1, or SIZ=00 with A[1:0]!=00; otherwise go to WORD0 with nREGSPACE<=0.
REQ-019 SHALL: lane mapping on WORD0 entry -- byte: CA1=A[1], UDS_SEL=~A[0], LDS_SEL=A[0]; word: CA1=A[1], both lanes; long: CA1=0, both lanes.
REQ-020 SHALL: WR_HI always equals ~CA1.
REQ-021 SHALL: act only on REG_TA rising edge (sampled 1, previous sample 0); REG_TA in IDLE, ACK, ERR ignored.
REQ-022 SHALL: on REG_TA edge with captured RnW=1, pulse LATCH_HI if CA1=0 else LATCH_LO, exactly one cycle, in the cycle following the edge sample.
REQ-023 SHALL: WORD0 on REG_TA edge -- long: go to WORD1, CA1<=1, nREGSPACE held 0 with no gap; byte/word: go to ACK, nREGSPACE<=1.
REQ-024 SHALL: WORD1 on REG_TA edge -> ACK, nREGSPACE<=1.
REQ-025 SHALL: ACK drives nTA=0 for exactly one cycle, then returns to IDLE; new nTS accepted in that IDLE cycle.
REQ-026 SHALL: ERR drives nTEA=0 for exactly one cycle, nREGSPACE never asserted, then IDLE.
REQ-027 SHALL: nTS while BUSY=1 is ignored; no queuing.
REQ-028 SHALL: nTA and nTEA never asserted in the same cycle; at most one nTA per accepted transfer.
REQ-029 SHALL: no timeout; WORD0/WORD1 wait indefinitely for REG_TA.

Reset
REQ-030 SHALL: on nRESET=0, immediately set state IDLE, nREGSPACE=1, nTA=1, nTEA=1, CA1=0, UDS_SEL=0, LDS_SEL=0, WR_HI=1, LATCH_HI=0, LATCH_LO=0, BUSY=0, REG_TA edge history=0.
REQ-031 SHALL: reset mid-transfer abandons it with no nTA/nTEA; first nTS after release is handled normally.

Verification
REQ-032 SHALL: byte write SIZ=01 A=01 -> nREGSPACE=0, CA1=0, UDS_SEL=0, LDS_SEL=1, WR_HI=1; one REG_TA -> nREGSPACE=1, nTA=0 one cycle.
REQ-033 SHALL: long read SIZ=00 A=00 -> CA1=0, LATCH_HI on first REG_TA; CA1=1, LATCH_LO on second; nREGSPACE low throughout; single nTA after second.
REQ-034 SHALL: line SIZ=11 and long A=10 -> nTEA=0 one cycle each, nREGSPACE stays 1, no nTA.
REQ-035 SHALL: nRESET pulsed low in WORD1 of long read -> all outputs at reset values, no nTA; next word read SIZ=10 A=10 completes with CA1=1, one nTA.
REQ-036 SHALL: nTS with nREGSEL=1, and REG_TA pulse while IDLE -> no output change, BUSY stays 0.
REQ-037 SHALL: REG_TA held high 3 cycles during byte read -> exactly one LATCH strobe, one nTA.
